// File: rtl/xnor_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xnor_check_pkg
// Brief    : Shared types, constants and reference function for the XNOR checker.
// Revision : 1.0
// ============================================================================
package xnor_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          NUM_DIRECTED = 4;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    function automatic logic xnor_ref(input logic x, input logic y);
        return ~(x ^ y);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xnor_check_sequencer_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Brief    : 16-bit Galois LFSR with synchronous load and step-on-demand.
// Revision : 1.0
// ============================================================================
module lfsr16
    import xnor_check_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] q
);

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= seed;
        end else if (load) begin
            r_state <= seed;
        end else if (advance) begin
            r_state <= (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign q = r_state;

endmodule
`default_nettype wire

// File: rtl/xnor_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : xnor_check_sequencer
// Brief    : Drives directed + pseudo-random x/y vectors and checks z_dut as XNOR.
// Revision : 1.0
// ============================================================================
module xnor_check_sequencer
    import xnor_check_pkg::*;
#(
    parameter int          N_RANDOM  = 100,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             z_dut,
    output logic             x,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam int               c_num_vec = NUM_DIRECTED + N_RANDOM;
    localparam int               c_k_w     = $clog2(c_num_vec + 1);
    localparam logic [c_k_w-1:0] c_k_last  = c_k_w'(c_num_vec - 1);
    localparam logic [c_k_w-1:0] c_k_dir   = c_k_w'(NUM_DIRECTED);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [15:0]      c_seed    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    state_t           r_state;
    logic [c_k_w-1:0] r_k;
    logic             r_x;
    logic             r_y;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_sample;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_first;

    logic             w_start_go;
    logic             w_running;
    logic             w_last;
    logic [c_k_w-1:0] w_k_next;
    logic             w_next_random;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_err_next;
    logic [CNT_W-1:0] w_k_idx;
    logic             w_advance;
    logic [15:0]      w_lfsr_q;
    logic [13:0]      w_lfsr_unused;

    assign w_start_go    = start && (r_state != RUN);
    assign w_running     = (r_state == RUN);
    assign w_last        = (r_k == c_k_last);
    assign w_k_next      = r_k + 1'b1;
    assign w_next_random = (w_k_next >= c_k_dir);
    assign w_mismatch    = (z_dut != xnor_ref(r_x, r_y));
    assign w_err_next    = (w_mismatch && (r_err != c_cnt_max)) ? r_err + 1'b1 : r_err;
    // The random value is consumed by the same edge that steps the LFSR
    assign w_advance     = w_running && !w_last && w_next_random;
    assign w_lfsr_unused = w_lfsr_q[15:2];

    if (c_k_w >= CNT_W) begin : g_idx_trunc
        assign w_k_idx = r_k[CNT_W-1:0];
    end else begin : g_idx_pad
        assign w_k_idx = {{(CNT_W - c_k_w){1'b0}}, r_k};
    end

    lfsr16 u_lfsr (
        .clk     (clk),
        .resetn  (resetn),
        .load    (w_start_go),
        .seed    (c_seed),
        .advance (w_advance),
        .q       (w_lfsr_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_x      <= 1'b0;
            r_y      <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_sample <= '0;
            r_err    <= '0;
            r_first  <= '1;
        end else if (w_start_go) begin
            r_state  <= RUN;
            r_k      <= '0;
            r_x      <= 1'b0;
            r_y      <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_sample <= '0;
            r_err    <= '0;
            r_first  <= '1;
        end else if (w_running) begin
            if (r_sample != c_cnt_max) begin
                r_sample <= r_sample + 1'b1;
            end
            r_err <= w_err_next;
            if (w_mismatch && (r_first == c_cnt_max)) begin
                r_first <= w_k_idx;
            end
            if (w_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_pass  <= (w_err_next == '0);
            end else begin
                r_k <= w_k_next;
                if (w_next_random) begin
                    r_x <= w_lfsr_q[1];
                    r_y <= w_lfsr_q[0];
                end else begin
                    r_x <= w_k_next[0];
                    r_y <= w_k_next[1];
                end
            end
        end
    end

    assign x             = r_x;
    assign y             = r_y;
    assign busy          = w_running;
    assign done          = r_done;
    assign pass          = r_pass;
    assign sample_count  = r_sample;
    assign err_count     = r_err;
    assign first_err_idx = r_first;

endmodule
`default_nettype wire

// File: tb/tb_xnor_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xnor_check_sequencer
// Brief    : Directed bench with a vector-list reference model for the checker.
// Revision : 1.0
// ============================================================================
module tb_xnor_check_sequencer;

    localparam int c_nv = 104;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters, selectable faulty unit under test
    logic        rst_a, start_a, z_a, x_a, y_a, busy_a, done_a, pass_a;
    logic [15:0] sc_a, ec_a, fe_a;
    int          mode_a;
    // Instance B: narrow counters, always an XOR unit
    logic        rst_b, start_b, z_b, x_b, y_b, busy_b, done_b, pass_b;
    logic [3:0]  sc_b, ec_b, fe_b;

    function automatic logic zfun(input int mode, input logic xi, input logic yi);
        if (mode == 1) return xi ^ yi;
        if (mode == 2) return ~(xi | yi);
        return ~(xi ^ yi);
    endfunction

    assign z_a = zfun(mode_a, x_a, y_a);
    assign z_b = x_b ^ y_b;

    xnor_check_sequencer u_dut_a (
        .clk (clk), .resetn (rst_a), .start (start_a), .z_dut (z_a),
        .x (x_a), .y (y_a), .busy (busy_a), .done (done_a), .pass (pass_a),
        .sample_count (sc_a), .err_count (ec_a), .first_err_idx (fe_a)
    );

    xnor_check_sequencer #(.N_RANDOM(20), .LFSR_SEED(16'hACE1), .CNT_W(4)) u_dut_b (
        .clk (clk), .resetn (rst_b), .start (start_b), .z_dut (z_b),
        .x (x_b), .y (y_b), .busy (busy_b), .done (done_b), .pass (pass_b),
        .sample_count (sc_b), .err_count (ec_b), .first_err_idx (fe_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Full expected vector list for one run of instance A
    logic vx [c_nv];
    logic vy [c_nv];
    logic [15:0] lfsr_after4;

    initial begin
        logic [15:0] s;
        s = 16'hACE1;
        for (int k = 0; k < c_nv; k++) begin
            if (k < 4) begin
                vx[k] = k[0];
                vy[k] = k[1];
            end else begin
                vx[k] = s[1];
                vy[k] = s[0];
                s = lfsr_step(s);
                if (k == 7) lfsr_after4 = s;
            end
        end
    end

    // Reference model: run phase, vector index and tallies
    int   m_st, m_k, m_s, m_e, m_f;
    logic m_x, m_y;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            m_st <= 0; m_k <= 0; m_s <= 0; m_e <= 0; m_f <= -1;
            m_x <= 1'b0; m_y <= 1'b0;
        end else if (m_st != 1 && start_a) begin
            m_st <= 1; m_k <= 0; m_s <= 0; m_e <= 0; m_f <= -1;
            m_x <= vx[0]; m_y <= vy[0];
        end else if (m_st == 1) begin
            m_s <= m_s + 1;
            if (zfun(mode_a, m_x, m_y) != (m_x == m_y)) begin
                m_e <= m_e + 1;
                if (m_f < 0) m_f <= m_k;
            end
            if (m_k == c_nv - 1) begin
                m_st <= 2;
            end else begin
                m_k <= m_k + 1;
                m_x <= vx[m_k + 1];
                m_y <= vy[m_k + 1];
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] fe_exp;
        logic        pass_exp;
        fe_exp   = (m_f < 0) ? 16'hFFFF : 16'(m_f);
        pass_exp = (m_st == 2) && (m_e == 0);
        check("cycle_outputs",
              {x_a, y_a, busy_a, done_a, pass_a, sc_a, ec_a, fe_a},
              {m_x, m_y, (m_st == 1), (m_st == 2), pass_exp, 16'(m_s), 16'(m_e), fe_exp});
        if ($isunknown(z_a)) begin
            n_fail++;
            $display("FAIL z_dut_x: got %b required known value", z_a);
        end
    end

    task automatic pulse_a();
        @(posedge clk); #2 start_a = 1'b1;
        @(posedge clk); #2 start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done_a && cyc < 400);
        check("done_a_timeout", done_a, 1'b1);
    endtask

    task automatic check_clean_run(input string tag, input int cyc);
        check({tag, "_cycles"}, cyc, c_nv);
        check({tag, "_pass"}, {done_a, pass_a}, 2'b11);
        check({tag, "_samples"}, sc_a, 16'd104);
        check({tag, "_errs"}, ec_a, 16'd0);
        check({tag, "_first"}, fe_a, 16'hFFFF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ones;
        mode_a = 0; start_a = 1'b0; start_b = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("reset_a", {x_a, y_a, busy_a, done_a, pass_a, sc_a, ec_a, fe_a},
              {5'b00000, 16'd0, 16'd0, 16'hFFFF});
        check("reset_b", {busy_b, done_b, sc_b, ec_b, fe_b}, {2'b00, 4'd0, 4'd0, 4'hF});

        // Hand-computed pins on the reference vector list
        check("model_lfsr_step1", lfsr_step(16'hACE1), 16'hE270);
        check("model_lfsr_step4", lfsr_after4, 16'h1C4E);
        check("model_vec4", {vx[4], vy[4]}, 2'b01);
        check("model_vec8", {vx[8], vy[8]}, 2'b10);
        check("model_vec3", {vx[3], vy[3]}, 2'b11);

        #10 rst_a = 1'b1; rst_b = 1'b1;

        // 1: correct unit
        pulse_a();
        wait_done_a(cyc);
        check_clean_run("s1", cyc);

        // 2: XOR unit fails every vector
        mode_a = 1;
        pulse_a();
        wait_done_a(cyc);
        check("s2_errs", ec_a, 16'd104);
        check("s2_first", fe_a, 16'd0);
        check("s2_pass", pass_a, 1'b0);

        // 3: NOR unit fails only on x = y = 1
        mode_a = 2;
        ones = 0;
        for (int k = 4; k < c_nv; k++) if (vx[k] && vy[k]) ones++;
        pulse_a();
        wait_done_a(cyc);
        check("s3_first", fe_a, 16'd3);
        check("s3_errs", ec_a, 16'(1 + ones));
        check("s3_pass", pass_a, 1'b0);

        // 4: reset mid-run clears without a clock edge
        mode_a = 0;
        pulse_a();
        repeat (50) @(posedge clk);
        #3 rst_a = 1'b0;
        #1;
        check("s4_abort", {x_a, y_a, busy_a, done_a, sc_a, ec_a, fe_a},
              {4'b0000, 16'd0, 16'd0, 16'hFFFF});
        @(posedge clk); #2 rst_a = 1'b1;
        pulse_a();
        wait_done_a(cyc);
        check_clean_run("s4", cyc);

        // 5: start held high gives back-to-back runs with one DONE cycle
        @(posedge clk); #2 start_a = 1'b1;
        wait_done_a(cyc);
        check("s5_first_run_cycles", cyc, c_nv + 1);
        @(posedge clk); #1;
        check("s5_restart", {busy_a, done_a}, 2'b10);
        wait_done_a(cyc);
        check("s5_second_run_cycles", cyc, c_nv);
        check("s5_pass", pass_a, 1'b1);
        start_a = 1'b0;
        pulse_a();
        repeat (10) @(posedge clk);
        #2 start_a = 1'b1;
        @(posedge clk); #2 start_a = 1'b0;
        wait_done_a(cyc);
        check("s5_ignored_start_cycles", cyc, c_nv - 11);
        check("s5_samples", sc_a, 16'd104);

        // 6: narrow counters saturate
        @(posedge clk); #2 start_b = 1'b1;
        @(posedge clk); #2 start_b = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done_b && cyc < 200);
        check("s6_done", done_b, 1'b1);
        check("s6_cycles", cyc, 24);
        check("s6_samples", sc_b, 4'd15);
        check("s6_errs", ec_b, 4'd15);
        check("s6_first", fe_b, 4'd0);
        check("s6_pass", pass_b, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xnor_check_sequencer.md
Name: xnor_check_sequencer

Overview:
- Self-checking stimulus sequencer for the 2-input XNOR datapath (x, y -> z = ~(x ^ y)).
- On start, drives a directed sweep of all four {y,x} codes, then N_RANDOM pseudo-random vectors. It checks the unit-under-test output z_dut against the expected XNOR every cycle.
- Reports mismatch count, the first failing vector index, and pass/fail.
- Sits beside the XNOR block in on-chip self-test and in benches as a synthesizable checker.

Parameters:
- N_RANDOM, 100: number of random vectors after the 4 directed ones; must be >= 1.
- LFSR_SEED, 16'hACE1: LFSR load value at each start; a value of 0 is replaced by 16'h0001.
- CNT_W, 16: width of the count and index outputs.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- z_dut  in  1  combinational result of the unit under test, driven from x and y
- x  out  1  registered stimulus
- y  out  1  registered stimulus
- busy  out  1  high while vectors are being applied
- done  out  1  high in DONE until the next start or reset
- pass  out  1  done && err_count == 0
- sample_count  out  CNT_W  vectors checked this run
- err_count  out  CNT_W  mismatching vectors this run
- first_err_idx  out  CNT_W  index of the first mismatching vector; all-ones if none

Behaviour:
- Reset is asserted while resetn is low, asynchronously. Reset values:
  - state IDLE; x = 0, y = 0.
  - busy, done, pass = 0.
  - sample_count, err_count = 0; first_err_idx = all-ones.
  - LFSR = seed.
- States: IDLE, RUN, DONE. T = 4 + N_RANDOM vectors, index k = 0..T-1.
- Start edge: at a rising edge with start = 1 in IDLE or DONE:
  - go to RUN; k = 0; {y,x} = 2'b00.
  - clear the counters; first_err_idx = all-ones; reload the LFSR; done = 0.
- Each rising edge in RUN:
  - Compare z_dut against ~(x ^ y) of the vector currently held. This is a one-cycle check latency.
  - sample_count++. On mismatch, err_count++, and first_err_idx = k if it is still all-ones.
  - If k == T-1: go to DONE. x and y hold their last values.
  - Otherwise k++ and load vector k+1.
- Vector source:
  - Directed, k = 0..3: {y,x} = k, giving 00, 01, 10, 11.
  - Random, k >= 4: {x,y} = lfsr[1:0].
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances exactly once per random vector loaded, never otherwise.
  - An identical seed gives an identical x/y trace.
- busy = (state == RUN). done and pass are registered and assert on the edge entering DONE.
- start while in RUN is ignored. A start level held high in DONE restarts on the next edge (back-to-back runs).
- Counters saturate at 2^CNT_W - 1 and never wrap. The k counter is internal and sized to hold T.
- Reset mid-RUN aborts immediately to the reset values. No partial results are retained.
- z_dut is compared 2-state. The bench is responsible for X detection on z_dut.

Decomposition:
- Package xnor_check_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - NUM_DIRECTED = 4;
  - LFSR_TAPS = 16'hB400;
  - the expected-function helper xnor_ref(x, y).
- One sub-module, lfsr16, with ports clk, resetn, load, seed, advance, and q[15:0].
- The FSM, counters and compare stay in xnor_check_sequencer.

Test Plan:
1. Correct DUT z = ~(x^y), defaults, 1-cycle start pulse -> busy for 104 cycles; then done = 1, pass = 1, sample_count = 104, err_count = 0, first_err_idx = 16'hFFFF.
2. Faulty DUT z = x^y -> err_count = 104, first_err_idx = 0, pass = 0.
3. Faulty DUT z = ~(x|y) (wrong only at x = y = 1) -> first_err_idx = 3, err_count = 1 + count of random vectors with lfsr[1:0] = 11 (predicted by a bench LFSR model), pass = 0.
4. resetn low at k = 50 -> x = y = 0, busy = 0 and counters cleared with no clock edge; a new start then reproduces scenario 1 results exactly.
5. start held high throughout -> no restart during RUN; one DONE cycle, then back-to-back runs with an identical x/y trace each run; a start pulse during RUN is ignored.
6. CNT_W = 4, N_RANDOM = 20, XOR DUT -> sample_count = 15 and err_count = 15 (saturated), done after 24 check cycles, first_err_idx = 0.
